rr_arb4: RTL and testbench
==========================

# rr_arb4

Four-requester round-robin arbiter that produces a registered 2-bit grant index with a valid qualifier. It sits directly upstream of the 2-to-4 one-hot decoder: `grant_idx` drives the decoder's `in`, and `grant_valid` gates the decoded select lines. A grant is held until the owner releases it, so the downstream one-hot select stays stable for a whole transaction.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum BUSY cycles before a forced release. Must be ≥ 2. Used only with `RR_ARB4_TIMEOUT_EN`.
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 4: request lines; bit i is requester i; level-sensitive.
- `release` input 1: the current owner ends its transaction. Sampled only in BUSY.
- `grant_idx` output 2: index of the current owner. Feeds the decoder `in`.
- `grant_valid` output 1: `grant_idx` is a live grant.
- `timeout` output 1: one-cycle pulse when a grant is force-released.

## Operation
- Two states:
  - IDLE: no owner.
  - BUSY: `grant_idx` is owned.
- Priority pointer `ptr[1:0]`: the highest-priority requester for the next arbitration.
- IDLE behaviour:
  - If `req` ≠ 0, pick the first set bit searching `ptr`, `ptr+1`, … mod 4.
  - Load that index into `grant_idx`, set `grant_valid`, go to BUSY.
  - If `req` = 0, stay in IDLE. `grant_idx` holds its last value.
- BUSY behaviour:
  - `grant_idx` is frozen.
  - Dropping or raising any `req` bit, including the owner's, has no effect.
  - On `release`=1: clear `grant_valid`, set `ptr` to `grant_idx+1` (3 wraps to 0), go to IDLE.
- `release` in IDLE is ignored.
- Back-to-back grants: at least one IDLE cycle, with `grant_valid` low, separates consecutive grants. This includes re-granting the same requester.
- Round-robin guarantee: with all four requesting continuously, grants cycle 0→1→2→3→0 after reset.
- Reset mid-operation: the state machine drops to IDLE immediately (asynchronously). No pending grant survives reset.

## Timing
- Reset values:
  - state IDLE
  - `ptr` 0
  - `grant_idx` 2'b00
  - `grant_valid` 0
  - `timeout` 0
- Grant latency: `req` sampled at edge N gives `grant_valid`=1 after edge N, i.e. in cycle N+1. This is one cycle of latency.
- Release latency: `release` sampled at edge M gives `grant_valid`=0 after edge M.
- The earliest next grant is sampled at edge M+1, so `grant_valid` re-asserts after edge M+1.
- All outputs are registered. There is no combinational path from `req` or `release` to any output.

## Configuration
- Macro: `RR_ARB4_TIMEOUT_EN`.
- When defined:
  - A BUSY-cycle counter of width $clog2(`TIMEOUT_CYCLES`+1) clears on entry to BUSY and increments each BUSY cycle.
  - When the counter equals `TIMEOUT_CYCLES`−1 and `release`=0, the block releases exactly as for a normal release and pulses `timeout` for one cycle, coincident with `grant_valid` falling.
  - If `release`=1 on that same cycle, it is a normal release and `timeout` stays 0.
- When undefined: no counter is built, `timeout` is tied to 0, and a grant is held indefinitely.

## Structure
- Shared package `rr_arb4_pkg`:
  - state enum {IDLE, BUSY}
  - `RR_ARB4_N` = 4
  - `RR_ARB4_IDX_W` = 2
- One sub-module, `rr_pick4`: combinational rotate-priority picker. Inputs: `req[3:0]` and `ptr[1:0]`. Outputs: `idx[1:0]` and `any`. Everything else is in `rr_arb4`.

## Test plan
- Reset then `req`=4'b1111 held; release each grant after 2 cycles → `grant_idx` sequence 0,1,2,3,0. `grant_valid` is high 2 cycles, then low 1 cycle, every period.
- `req`=4'b0100 only; grant, then release → `grant_idx`=2. Re-grant of 2 follows after exactly one idle cycle; `ptr` is 3 in between.
- Requester 1 granted, then `req` changes to 4'b1000 while in BUSY → `grant_idx` stays 1 until `release`. The next grant is 3.
- `release`=1 pulsed while IDLE with `req`=0 → no state change; `grant_valid` stays 0 and `ptr` is unchanged.
- `reset_n` driven low mid-BUSY between clock edges → `grant_valid`=0 immediately. After reset deassert with `req`=4'b1010, the first grant is 1.
- With `RR_ARB4_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, grant requester 0 and never release → `grant_valid` high 4 cycles, then `timeout` pulses for 1 cycle as `grant_valid` falls. The next grant starts searching from 1.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared types and sizes for the four-requester round-robin arbiter.
// No logic of its own; imported by rr_arb4 and rr_pick4.
// Only IDX_W and N are used to size ports and internal registers.
package rr_arb4_pkg;

  localparam int RR_ARB4_N     = 4;
  localparam int RR_ARB4_IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb4_pick4.sv
// Rotate-priority picker: returns the first set request at or after ptr (mod 4).
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is used.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [RR_ARB4_N-1:0]     req,
  input  logic [RR_ARB4_IDX_W-1:0] ptr,
  output logic [RR_ARB4_IDX_W-1:0] idx,
  output logic                     any
);

  logic [RR_ARB4_IDX_W-1:0] cand;

  // Walk from the lowest priority offset up so the highest-priority hit is written last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = ptr;
    for (int k = RR_ARB4_N - 1; k >= 0; k--) begin
      cand = ptr + RR_ARB4_IDX_W'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter, 4 requesters; registered grant index held until the owner releases.
// Latency: request sampled at edge N gives grant_valid in cycle N+1; one idle cycle between grants.
// Optional forced release after TIMEOUT_CYCLES busy cycles when RR_ARB4_TIMEOUT_EN is defined.
// The release input is named release_i because `release` is a reserved word.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [RR_ARB4_N-1:0]     req,
  input  logic                     release_i,
  output logic [RR_ARB4_IDX_W-1:0] grant_idx,
  output logic                     grant_valid,
  output logic                     timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_cfg_chk
    $error("rr_arb4: TIMEOUT_CYCLES must be >= 2");
  end

  state_e                   state_q, state_d;
  logic [RR_ARB4_IDX_W-1:0] ptr_q, ptr_d;
  logic [RR_ARB4_IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic                     grant_valid_q, grant_valid_d;
  logic [RR_ARB4_IDX_W-1:0] pick_idx;
  logic                     pick_any;
  logic                     force_rel;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef RR_ARB4_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  // Busy-cycle counter: zero on the cycle the grant is taken, counts while owned.
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A voluntary release on the last allowed cycle wins over the forced one.
  assign force_rel = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !release_i;

  // Counter and one-cycle timeout pulse, aligned with grant_valid falling.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= force_rel;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state: grab the picked requester in IDLE, hold until release in BUSY.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (release_i || force_rel) begin
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any pending grant immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed scenarios plus random traffic against a reference model.
module tb_rr_arb4;

  localparam int TO = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       release_i;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the grant, where the search starts next time.
  bit m_busy;
  int m_idx;
  int m_ptr;
  int m_cnt;
  bit m_tmo;

  always #5 clock = ~clock;

  rr_arb4 #(.TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .release_i   (release_i),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_idx  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_tmo  = 0;
  endtask

  // One clock edge of the arbiter rules, given the sampled inputs.
  task automatic model_edge(input logic [3:0] r, input logic rl);
    bit forced;
    m_tmo = 0;
    if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (r[(m_ptr + k) % 4]) begin
          m_idx  = (m_ptr + k) % 4;
          m_busy = 1;
          m_cnt  = 0;
          break;
        end
      end
    end else begin
      forced = 0;
`ifdef RR_ARB4_TIMEOUT_EN
      forced = (m_cnt == TO - 1) && !rl;
`endif
      if (rl || forced) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 4;
        m_tmo  = forced;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Drive inputs, take one edge, then compare all outputs on the falling edge.
  task automatic step(input logic [3:0] r, input logic rl);
    req       = r;
    release_i = rl;
    @(posedge clock);
    model_edge(r, rl);
    @(negedge clock);
    chk("grant_valid", int'(grant_valid), int'(m_busy));
    chk("grant_idx", int'(grant_idx), m_idx);
    chk("timeout", int'(timeout), int'(m_tmo));
  endtask

  initial begin
    int saved_ptr;
    reset_n   = 1'b0;
    req       = 4'b0000;
    release_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_valid", int'(grant_valid), 0);
    chk("rst_idx", int'(grant_idx), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_ptr", int'(dut.ptr_q), 0);
    reset_n = 1'b1;

    // All four requesting: grants rotate 0,1,2,3,0; valid high 2 cycles, low 1.
    for (int p = 0; p < 5; p++) begin
      step(4'b1111, 1'b0);
      chk("rr_seq_idx", int'(grant_idx), p % 4);
      chk("rr_seq_vld1", int'(grant_valid), 1);
      step(4'b1111, 1'b0);
      chk("rr_seq_vld2", int'(grant_valid), 1);
      step(4'b1111, 1'b1);
      chk("rr_seq_gap", int'(grant_valid), 0);
    end

    // Single requester 2: re-grant after exactly one idle cycle, ptr 3 in between.
    step(4'b0100, 1'b0);
    chk("solo_idx", int'(grant_idx), 2);
    step(4'b0100, 1'b1);
    chk("solo_gap_vld", int'(grant_valid), 0);
    chk("solo_gap_ptr", int'(dut.ptr_q), 3);
    step(4'b0100, 1'b0);
    chk("solo_regrant_vld", int'(grant_valid), 1);
    chk("solo_regrant_idx", int'(grant_idx), 2);
    step(4'b0000, 1'b1);

    // Requests change while busy: owner 1 holds, next grant is 3.
    step(4'b0010, 1'b0);
    chk("hold_first", int'(grant_idx), 1);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    chk("hold_frozen", int'(grant_idx), 1);
    chk("hold_vld", int'(grant_valid), 1);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b0);
    chk("hold_next", int'(grant_idx), 3);
    step(4'b0000, 1'b1);

    // Release while idle with no requests is ignored.
    saved_ptr = int'(dut.ptr_q);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("idle_rel_vld", int'(grant_valid), 0);
    chk("idle_rel_ptr", int'(dut.ptr_q), saved_ptr);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3));
    end

    // Asynchronous reset in the middle of a busy period.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b1111, 1'b0);
    chk("pre_rst_vld", int'(grant_valid), 1);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_vld", int'(grant_valid), 0);
    chk("async_rst_ptr", int'(dut.ptr_q), 0);
    @(negedge clock);
    reset_n = 1'b1;
    step(4'b1010, 1'b0);
    chk("post_rst_idx", int'(grant_idx), 1);
    chk("post_rst_vld", int'(grant_valid), 1);
    step(4'b0000, 1'b1);

`ifdef RR_ARB4_TIMEOUT_EN
    // Requester 0 never releases: forced release after TO cycles.
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < TO; c++) begin
      step(4'b0001, 1'b0);
      chk("to_hold_vld", int'(grant_valid), 1);
      chk("to_hold_tmo", int'(timeout), 0);
    end
    step(4'b0001, 1'b0);
    chk("to_fire_vld", int'(grant_valid), 0);
    chk("to_fire_tmo", int'(timeout), 1);
    step(4'b1111, 1'b0);
    chk("to_pulse_end", int'(timeout), 0);
    chk("to_next_idx", int'(grant_idx), 1);
    step(4'b0000, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
